mem_if_axi_lite_master: RTL and testbench

// - Bridges the core's req/gnt/rvalid memory port onto an AXI4-Lite master interface.
// - One instance serves the instruction port, one serves the data port. Each drives the
//   AXI slave memories that the system testbench backs with VIP memory models.
// - Single outstanding transaction; the core sees a response pulse per granted request.

---
 rtl/mem_if_axi_lite_master_if.sv | 42 ++++
 rtl/mem_if_axi_lite_master.sv | 142 ++++++++++++++
 tb/tb_mem_if_axi_lite_master.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_axi_lite_master_if.sv
// AXI4-Lite bus bundle between a single-outstanding master and its slave memory.
// The master modport drives the address/data/valid side; the slave drives readies and responses.
interface mem_if_axi_lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/mem_if_axi_lite_master.sv
// Core req/gnt/rvalid memory port to AXI4-Lite master bridge, one transaction in flight.
// Every granted request produces exactly one rvalid_o pulse unless reset aborts it.
module mem_if_axi_lite_master #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] AXI_PROT   = 3'b000,
  parameter bit         ALIGN_ADDR = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  mem_if_axi_lite_master_if.master m_axi
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_R  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [ADDR_WIDTH-1:0]   addr_aligned;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH/8-1:0] strb_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic                    err_reg;
  logic                    aw_done_reg;
  logic                    w_done_reg;
  logic                    aw_hs, w_hs, r_hs, b_hs;

  // Address bits [1:0] are forced to zero bit by bit when alignment is enabled.
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_align
      if (ALIGN_ADDR && gi < 2) begin : g_zero
        assign addr_aligned[gi] = 1'b0;
      end else begin : g_pass
        assign addr_aligned[gi] = addr_i[gi];
      end
    end
  endgenerate

  assign aw_hs = m_axi.awvalid & m_axi.awready;
  assign w_hs  = m_axi.wvalid  & m_axi.wready;
  assign r_hs  = m_axi.rvalid  & m_axi.rready;
  assign b_hs  = m_axi.bvalid  & m_axi.bready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_i) state_next = we_i ? WR_AW : RD_A;
      RD_A:    if (m_axi.arready) state_next = RD_R;
      RD_R:    if (m_axi.rvalid) state_next = DONE;
      // AW and W complete independently; leave once both have been accepted.
      WR_AW:   if ((aw_done_reg | aw_hs) & (w_done_reg | w_hs)) state_next = WR_B;
      WR_B:    if (m_axi.bvalid) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt_o         = 1'b0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.bready  = 1'b0;
    rvalid_o      = 1'b0;
    err_o         = 1'b0;
    case (state_reg)
      IDLE:  gnt_o = req_i;
      RD_A:  m_axi.arvalid = 1'b1;
      RD_R:  m_axi.rready = 1'b1;
      WR_AW: begin
        m_axi.awvalid = ~aw_done_reg;
        m_axi.wvalid  = ~w_done_reg;
      end
      WR_B:  m_axi.bready = 1'b1;
      DONE: begin
        rvalid_o = 1'b1;
        err_o    = err_reg;
      end
      default: ;
    endcase
  end

  // Payload registers only change on grant, so every channel stays stable while valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg    <= '0;
      wdata_reg   <= '0;
      strb_reg    <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      if (gnt_o) begin
        addr_reg    <= addr_aligned;
        wdata_reg   <= wdata_i;
        strb_reg    <= be_i;
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
      end
      if (aw_hs) aw_done_reg <= 1'b1;
      if (w_hs)  w_done_reg  <= 1'b1;
      if (r_hs) begin
        rdata_reg <= m_axi.rdata;
        err_reg   <= (m_axi.rresp != 2'b00);
      end
      if (b_hs) err_reg <= (m_axi.bresp != 2'b00);
    end
  end

  assign m_axi.awaddr = addr_reg;
  assign m_axi.araddr = addr_reg;
  assign m_axi.awprot = AXI_PROT;
  assign m_axi.arprot = AXI_PROT;
  assign m_axi.wdata  = wdata_reg;
  assign m_axi.wstrb  = strb_reg;
  assign rdata_o      = rdata_reg;
endmodule

// File: tb/tb_mem_if_axi_lite_master.sv
// Randomised bench for mem_if_axi_lite_master: an AXI-Lite slave memory with random stalls,
// and a transaction-level model that predicts every output on every cycle.
module tb_mem_if_axi_lite_master;
  localparam logic [2:0] PROT = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;

  mem_if_axi_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  mem_if_axi_lite_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .AXI_PROT(PROT), .ALIGN_ADDR(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .m_axi(axi.master)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h0001_0003) ^ 32'h5A5A_A5A5;
  endfunction

  // Slave answers SLVERR for anything in the upper 4 KiB half of the memory window.
  function automatic logic [1:0] resp_for(input logic [31:0] a);
    return a[12] ? 2'b10 : 2'b00;
  endfunction

  function automatic int pick(input int fix);
    return (fix >= 0) ? fix : int'($urandom_range(0, 3));
  endfunction

  logic [31:0] smem [0:2047];
  logic [31:0] rmem [0:2047];

  // ---------------- slave memory ----------------
  int fix_ar = 0, fix_r = 0, fix_aw = 0, fix_w = 0, fix_b = 0;
  logic [31:0] last_awaddr = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;

  initial begin
    bit ar_st = 0, aw_st = 0, w_st = 0, r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
    bit r_hs_q = 0, b_hs_q = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    int ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0, b_lat = 0;
    logic [31:0] r_addr = '0, wr_addr = '0, wr_data = '0;
    logic [3:0]  wr_strb = '0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ar_st = 0; aw_st = 0; w_st = 0; r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        r_hs_q = 0; b_hs_q = 0;
        axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.bvalid = 0; axi.rvalid = 0;
      end else begin
        if (r_hs_q) begin axi.rvalid = 0; r_hs_q = 0; end
        if (b_hs_q) begin axi.bvalid = 0; b_hs_q = 0; end
        if (axi.arvalid && !ar_st) begin ar_st = 1; ar_cnt = 0; ar_lat = pick(fix_ar); end
        if (axi.awvalid && !aw_st) begin aw_st = 1; aw_cnt = 0; aw_lat = pick(fix_aw); end
        if (axi.wvalid && !w_st) begin w_st = 1; w_cnt = 0; w_lat = pick(fix_w); end
        axi.arready = axi.arvalid && (ar_cnt >= ar_lat);
        axi.awready = axi.awvalid && (aw_cnt >= aw_lat);
        axi.wready  = axi.wvalid && (w_cnt >= w_lat);
        if (r_pend) begin
          if (r_cnt >= r_lat) begin
            axi.rvalid = 1; axi.rdata = smem[r_addr[12:2]]; axi.rresp = resp_for(r_addr); r_pend = 0;
          end else r_cnt++;
        end
        if (b_pend) begin
          if (b_cnt >= b_lat) begin
            axi.bvalid = 1; axi.bresp = resp_for(wr_addr); b_pend = 0;
          end else b_cnt++;
        end
        #2;
        if (axi.arvalid) begin
          if (axi.arready) begin
            ar_st = 0; r_pend = 1; r_cnt = 0; r_lat = pick(fix_r);
            r_addr = axi.araddr; last_araddr = axi.araddr;
          end else ar_cnt++;
        end
        if (axi.awvalid) begin
          if (axi.awready) begin
            aw_st = 0; aw_got = 1; wr_addr = axi.awaddr; last_awaddr = axi.awaddr;
          end else aw_cnt++;
        end
        if (axi.wvalid) begin
          if (axi.wready) begin
            w_st = 0; w_got = 1; wr_data = axi.wdata; wr_strb = axi.wstrb; last_wstrb = axi.wstrb;
          end else w_cnt++;
        end
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; b_lat = pick(fix_b);
        end
        if (axi.rvalid && axi.rready) r_hs_q = 1;
        if (axi.bvalid && axi.bready) begin
          b_hs_q = 1;
          if (resp_for(wr_addr) == 2'b00)
            for (int b = 0; b < 4; b++)
              if (wr_strb[b]) smem[wr_addr[12:2]][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // ---------------- transaction model + per-cycle compare ----------------
  int cyc = 0, gnt_cnt = 0, done_cnt = 0, gnt_cyc = 0, done_cyc = 0, aw_hi = 0, w_hi = 0;
  bit busy = 0;
  logic last_err_seen = 0;
  logic [31:0] last_rdata = '0;

  initial begin
    bit ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0, exp_rv;
    logic t_we = 0, t_err = 0;
    logic [31:0] t_addr = '0, t_data = '0, t_rdata = '0;
    logic [3:0]  t_be = '0;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (!rst_n) begin
        chk1("rst_gnt", gnt_o, 1'b0);
        chk1("rst_rvalid", rvalid_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk1("rst_arvalid", axi.arvalid, 1'b0);
        chk1("rst_awvalid", axi.awvalid, 1'b0);
        chk1("rst_wvalid", axi.wvalid, 1'b0);
        chk1("rst_rready", axi.rready, 1'b0);
        chk1("rst_bready", axi.bready, 1'b0);
        busy = 0;
        last_rdata = '0;
      end else begin
        exp_rv = busy && (t_we ? b_d : r_d);
        chk1("gnt", gnt_o, req_i && !busy);
        chk1("arvalid", axi.arvalid, busy && !t_we && !ar_d);
        chk1("rready", axi.rready, busy && !t_we && ar_d && !r_d);
        chk1("awvalid", axi.awvalid, busy && t_we && !aw_d);
        chk1("wvalid", axi.wvalid, busy && t_we && !w_d);
        chk1("bready", axi.bready, busy && t_we && aw_d && w_d && !b_d);
        chk1("rvalid_o", rvalid_o, exp_rv);
        if (axi.arvalid) begin chk("araddr", axi.araddr, t_addr); chk("arprot", 32'(axi.arprot), 32'(PROT)); end
        if (axi.awvalid) begin chk("awaddr", axi.awaddr, t_addr); chk("awprot", 32'(axi.awprot), 32'(PROT)); end
        if (axi.wvalid) begin chk("wdata", axi.wdata, t_data); chk("wstrb", 32'(axi.wstrb), 32'(t_be)); end
        if (axi.awvalid) aw_hi++;
        if (axi.wvalid) w_hi++;
        if (rvalid_o && exp_rv) begin
          chk1("err_o", err_o, t_err);
          chk("rdata_o", rdata_o, t_we ? last_rdata : t_rdata);
          if (!t_we) last_rdata = t_rdata;
          else if (!t_err)
            for (int b = 0; b < 4; b++)
              if (t_be[b]) rmem[t_addr[12:2]][8*b +: 8] = t_data[8*b +: 8];
          last_err_seen = err_o;
          busy = 0;
          done_cnt++;
          done_cyc = cyc;
          $display("TXN %0d %s addr=0x%08h data=0x%08h err=%b cyc=%0d", done_cnt, t_we ? "WR" : "RD",
                   t_addr, t_we ? t_data : rdata_o, err_o, cyc - gnt_cyc);
        end else if (busy) begin
          if (axi.arvalid && axi.arready) ar_d = 1;
          if (axi.rvalid && axi.rready) r_d = 1;
          if (axi.awvalid && axi.awready) aw_d = 1;
          if (axi.wvalid && axi.wready) w_d = 1;
          if (axi.bvalid && axi.bready) b_d = 1;
        end
        if (gnt_o && !busy) begin
          busy = 1;
          t_we = we_i; t_addr = {addr_i[31:2], 2'b00}; t_be = be_i; t_data = wdata_i;
          t_rdata = rmem[t_addr[12:2]];
          t_err = (resp_for(t_addr) != 2'b00);
          ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0;
          aw_hi = 0; w_hi = 0;
          gnt_cnt++;
          gnt_cyc = cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    int n = 0;
    req_i = 1'b1; we_i = we; addr_i = a; be_i = be; wdata_i = d;
    #1;
    while (!gnt_o && n < 200) begin @(negedge clk); #1; n++; end
    chk1("gnt_timeout", gnt_o, 1'b1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin @(negedge clk); #4; n++; end
    chk1("done_timeout", done_cnt >= target, 1'b1);
  endtask

  initial begin
    int g0, d0, n;
    for (int i = 0; i < 2048; i++) begin smem[i] = init_val(i); rmem[i] = init_val(i); end
    smem[0] = 32'h1000_0113; rmem[0] = 32'h1000_0113;
    repeat (3) @(negedge clk);
    #5 rst_n = 1'b1;

    // zero-wait read of address 0
    @(negedge clk); issue(1'b0, 32'h0, 4'hF, 32'h0);
    @(negedge clk); req_i = 1'b0;
    wait_done(1);
    chk("rd0_latency", 32'(done_cyc - gnt_cyc), 32'd3);
    chk("rd0_rdata", rdata_o, 32'h1000_0113);
    chk1("rd0_err", last_err_seen, 1'b0);
    chk("rd0_araddr", last_araddr, 32'h0);

    // full-word write with AW accepted two cycles late
    fix_aw = 2;
    @(negedge clk); issue(1'b1, 32'h70, 4'b1111, 32'h0000_00FF);
    @(negedge clk); req_i = 1'b0;
    wait_done(2);
    fix_aw = 0;
    chk("wr70_aw_cycles", 32'(aw_hi), 32'd3);
    chk("wr70_w_cycles", 32'(w_hi), 32'd1);
    chk("wr70_done", 32'(done_cnt), 32'd2);
    chk("wr70_mem", smem[28], 32'h0000_00FF);

    // zero-wait write latency and sub-word write to an unaligned address
    @(negedge clk); issue(1'b1, 32'h73, 4'b0010, 32'hA5A5_5A5A);
    @(negedge clk); req_i = 1'b0;
    wait_done(3);
    chk("wr73_latency", 32'(done_cyc - gnt_cyc), 32'd3);
    chk("wr73_awaddr", last_awaddr, 32'h70);
    chk("wr73_wstrb", 32'(last_wstrb), 32'h2);
    chk("wr73_mem", smem[28], 32'h0000_5AFF);

    // SLVERR read, then an ordinary read is granted and completes cleanly
    @(negedge clk); issue(1'b0, 32'h1000, 4'hF, 32'h0);
    @(negedge clk); req_i = 1'b0;
    wait_done(4);
    chk1("slverr_err", last_err_seen, 1'b1);
    @(negedge clk); issue(1'b0, 32'h70, 4'hF, 32'h0);
    @(negedge clk); req_i = 1'b0;
    wait_done(5);
    chk1("after_err_err", last_err_seen, 1'b0);
    chk("after_err_rdata", rdata_o, 32'h0000_5AFF);

    // four reads with req held high throughout
    g0 = gnt_cnt; d0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); issue(1'b0, 32'(k * 4), 4'hF, 32'h0);
    end
    @(negedge clk); req_i = 1'b0;
    wait_done(d0 + 4);
    chk("held_gnts", 32'(gnt_cnt - g0), 32'd4);
    chk("held_dones", 32'(done_cnt - d0), 32'd4);

    // reset asserted while waiting in the write-response phase
    fix_b = 8;
    d0 = done_cnt;
    @(negedge clk); issue(1'b1, 32'h80, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk); req_i = 1'b0;
    n = 0;
    #1;
    while (!axi.bready && n < 50) begin @(negedge clk); #1; n++; end
    chk1("bready_reached", axi.bready, 1'b1);
    #4 rst_n = 1'b0;
    #1;
    chk1("async_arvalid", axi.arvalid, 1'b0);
    chk1("async_awvalid", axi.awvalid, 1'b0);
    chk1("async_wvalid", axi.wvalid, 1'b0);
    chk1("async_rready", axi.rready, 1'b0);
    chk1("async_bready", axi.bready, 1'b0);
    chk1("async_rvalid_o", rvalid_o, 1'b0);
    repeat (2) @(negedge clk);
    #5 rst_n = 1'b1;
    fix_b = 0;
    chk("rst_no_rvalid", 32'(done_cnt), 32'(d0));
    @(negedge clk); issue(1'b0, 32'h80, 4'hF, 32'h0);
    @(negedge clk); req_i = 1'b0;
    wait_done(d0 + 1);
    chk("post_rst_rdata", rdata_o, init_val(32));

    // randomised traffic with random stalls on every channel
    fix_ar = -1; fix_r = -1; fix_aw = -1; fix_w = -1; fix_b = -1;
    d0 = done_cnt;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        req_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h1FFF)),
            4'($urandom_range(1, 15)), $urandom);
    end
    @(negedge clk); req_i = 1'b0;
    wait_done(d0 + 250);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
